alu32_arbiter: RTL and testbench
================================

// Module: alu32_arbiter
// PURPOSE
//  Shares a single combinational 32-bit ALU datapath (And32 and related units) between two requesters.
//  - Arbitration is round-robin.
//  - Each requester hands over one operation (op + two operands) through a valid/ready handshake.
//  - The block drives the shared ALU, waits a fixed settle time, captures the result and returns it to the granted requester.
//  - Sits between the instruction-side sequencers and the ALU32 datapath.
// PARAMETERS
//  WIDTH        32  operand/result width
//  OPW          3   ALU opcode width (passed through, not decoded)
//  EXEC_CYCLES  1   cycles operands are held on the ALU before capture; legal 1..15
// PORTS
//  Clk       in   1          clock, rising edge
//  Rst       in   1          reset, asynchronous, active-high
//  ReqValid  in   2          requester i has an operation pending
//  ReqReady  out  2          requester i's operation accepted this cycle
//  ReqOp     in   2*OPW      opcode, requester i at [i*OPW +: OPW]
//  ReqA      in   2*WIDTH    operand A, requester i at [i*WIDTH +: WIDTH]
//  ReqB      in   2*WIDTH    operand B, same packing
//  RspValid  out  2          result for requester i available
//  RspReady  in   2          requester i takes the result
//  RspData   out  WIDTH      captured result
//  AluOp     out  OPW        opcode to shared ALU
//  AluIn1    out  WIDTH      operand A to shared ALU
//  AluIn2    out  WIDTH      operand B to shared ALU
//  AluOut    in   WIDTH      shared ALU result (combinational from AluIn1/AluIn2/AluOp)
//  Busy      out  1          high whenever state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  - Reset (async, any state): state=IDLE, Last=1 (requester 0 wins the first tie).
//    All outputs go to 0; latched op/operands are cleared; an in-flight operation is dropped with no response.
//  - IDLE:
//    - Grant = the only valid requester; if both are valid, grant = !Last.
//    - ReqReady[g] is combinational: asserted exactly in the accept cycle, only when state==IDLE.
//    - On accept: latch op/A/B, load Cnt=EXEC_CYCLES-1, go to EXEC.
//    - No request: stay in IDLE; ReqReady=0.
//  - EXEC:
//    - AluOp/AluIn1/AluIn2 are driven from the latched registers and stay stable for the whole state.
//    - Cnt decrements each cycle.
//    - When Cnt==0: capture AluOut into Result, go to RESP.
//  - RESP:
//    - RspValid[g]=1 and RspData=Result, held until RspReady[g]=1.
//    - On the handshake edge: Last=g, go to IDLE.
//    - RspReady on the non-granted index is ignored.
//  - Outside RESP: RspValid=0 and RspData=0. Outside EXEC: AluIn1/AluIn2/AluOp=0.
//  - Latency: accept at edge N; RspValid rises after edge N+EXEC_CYCLES.
//    - Minimum accept-to-accept spacing is EXEC_CYCLES+2 cycles.
//  - No pipelining: new requests are not accepted in EXEC or RESP.
//    - Requesters keep ReqValid high while waiting; dropping ReqValid before accept has no effect.
//  - Result is captured at full WIDTH with no truncation or sign handling; the op is opaque to this block.
//  - Requester g may reassert ReqValid while its own response is pending.
//    It is not accepted before the next IDLE, and round-robin then favours the other requester if both are valid.
// CONFIGURATION
//  ALU_ARB_STATS_EN defined:
//   - Adds output ports GrantCnt0 [15:0] and GrantCnt1 [15:0].
//   - Each counts completed response handshakes per requester, wraps 16'hFFFF->0, and is cleared by Rst.
//  ALU_ARB_STATS_EN undefined: these ports and the counters do not exist; all other behaviour is identical.
// TESTING
//  Bench: the shared ALU is an And32 on AluIn1/AluIn2; AluOp is checked for pass-through only.
//  1. Single request, EXEC_CYCLES=1:
//     - Stimulus: req0 A=32'hF0F0_1234, B=32'h0FF0_FFFF, op=3'd0, RspReady0=1.
//     - Response: ReqReady0 pulses 1 cycle; RspValid0 rises 2 edges later; RspData=32'h00F0_1234; AluOp=0 during EXEC.
//  2. Simultaneous requests after reset:
//     - Stimulus: req0 A=B=32'hFFFF_FFFF; req1 A=32'hAAAA_AAAA, B=32'h5555_5555.
//     - Response: req0 served first (RspData=32'hFFFF_FFFF), then req1 (RspData=0); grants alternate across 4 further tied rounds.
//  3. Response backpressure:
//     - Stimulus: hold RspReady0=0 for 5 cycles while req1 is valid.
//     - Response: RspValid0 and RspData stay stable, ReqReady1 stays 0 and Busy=1; req1 is accepted the cycle after the handshake.
//  4. EXEC_CYCLES=4:
//     - Response: AluIn1/AluIn2 are stable for exactly 4 cycles; RspValid rises 5 edges after accept.
//  5. Rst asserted mid-EXEC:
//     - Response: outputs are 0 immediately (async); no RspValid follows; the next tie grants req0.
//  6. ALU_ARB_STATS_EN:
//     - Stimulus: 3 req0 and 2 req1 completions.
//     - Response: GrantCnt0=3 and GrantCnt1=2; both read 0 after Rst.

Source files
------------

// File: rtl/alu32_arbiter.sv
// alu32_arbiter
//   Round-robin sharing of one combinational 32-bit ALU between two
//   requesters. Each requester hands over one operation via valid/ready.
//   The block drives the ALU for EXEC_CYCLES cycles, captures the result,
//   and returns it to the granted requester through a valid/ready response.
//   Optional feature macro: ALU_ARB_STATS_EN adds per-requester completion
//   counters on GrantCnt0 / GrantCnt1.
module alu32_arbiter #(
    parameter int WIDTH       = 32,
    parameter int OPW         = 3,
    parameter int EXEC_CYCLES = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [1:0]         ReqValid,
    output logic [1:0]         ReqReady,
    input  logic [2*OPW-1:0]   ReqOp,
    input  logic [2*WIDTH-1:0] ReqA,
    input  logic [2*WIDTH-1:0] ReqB,
    output logic [1:0]         RspValid,
    input  logic [1:0]         RspReady,
    output logic [WIDTH-1:0]   RspData,
    output logic [OPW-1:0]     AluOp,
    output logic [WIDTH-1:0]   AluIn1,
    output logic [WIDTH-1:0]   AluIn2,
    input  logic [WIDTH-1:0]   AluOut,
    output logic               Busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]        GrantCnt0,
    output logic [15:0]        GrantCnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_s;

    // Operation registers double as the ALU drive: they hold the operands
    // during EXEC and are zeroed on capture, so the ALU sees 0 elsewhere.
    logic [OPW-1:0]     op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   result_r;
    logic [1:0]         rsp_valid_r;
    logic               busy_r;
    logic [3:0]         cnt_r;
    logic               gnt_r;     // requester owning the in-flight operation
    logic               last_r;    // requester served most recently

    logic               grant_s;
    logic               accept_s;
    logic               capture_s;
    logic               handshake_s;
    logic [1:0]         ready_s;

    // State register; reset drops any in-flight operation.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Grant selection, next-state decode and per-cycle control strobes.
    always_comb begin
        next_s      = state_r;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        handshake_s = 1'b0;
        ready_s     = 2'b00;
        grant_s     = 1'b0;

        case (ReqValid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_r;
            default: grant_s = 1'b0;
        endcase

        case (state_r)
            ST_IDLE: begin
                if (ReqValid != 2'b00) begin
                    accept_s = 1'b1;
                    ready_s  = grant_s ? 2'b10 : 2'b01;
                    next_s   = ST_EXEC;
                end else begin
                    next_s   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_r == 4'd0) begin
                    capture_s = 1'b1;
                    next_s    = ST_RESP;
                end else begin
                    next_s    = ST_EXEC;
                end
            end
            ST_RESP: begin
                if (RspReady[gnt_r]) begin
                    handshake_s = 1'b1;
                    next_s      = ST_IDLE;
                end else begin
                    next_s      = ST_RESP;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // Accept strobe is combinational; it is masked while reset is held so
    // every output reads 0 during reset.
    assign ReqReady = ready_s & {2{~Rst}};

    // Operation latch, execute countdown, result capture and response hold.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            result_r    <= '0;
            rsp_valid_r <= 2'b00;
            busy_r      <= 1'b0;
            cnt_r       <= 4'd0;
            gnt_r       <= 1'b0;
            last_r      <= 1'b1;
        end else begin
            if (accept_s) begin
                op_r   <= grant_s ? ReqOp[OPW +: OPW]   : ReqOp[0 +: OPW];
                a_r    <= grant_s ? ReqA[WIDTH +: WIDTH] : ReqA[0 +: WIDTH];
                b_r    <= grant_s ? ReqB[WIDTH +: WIDTH] : ReqB[0 +: WIDTH];
                cnt_r  <= 4'(EXEC_CYCLES - 1);
                gnt_r  <= grant_s;
                busy_r <= 1'b1;
            end else if (capture_s) begin
                result_r    <= AluOut;
                rsp_valid_r <= gnt_r ? 2'b10 : 2'b01;
                op_r        <= '0;
                a_r         <= '0;
                b_r         <= '0;
            end else if (state_r == ST_EXEC) begin
                cnt_r <= cnt_r - 4'd1;
            end else if (handshake_s) begin
                last_r      <= gnt_r;
                rsp_valid_r <= 2'b00;
                result_r    <= '0;
                busy_r      <= 1'b0;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign AluOp    = op_r;
    assign AluIn1   = a_r;
    assign AluIn2   = b_r;
    assign RspValid = rsp_valid_r;
    assign RspData  = result_r;
    assign Busy     = busy_r;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0_r;
    logic [15:0] grant_cnt1_r;

    // Completed response handshakes per requester, wrapping at 16 bits.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            grant_cnt0_r <= 16'd0;
            grant_cnt1_r <= 16'd0;
        end else if (handshake_s) begin
            if (gnt_r) begin
                grant_cnt1_r <= grant_cnt1_r + 16'd1;
            end else begin
                grant_cnt0_r <= grant_cnt0_r + 16'd1;
            end
        end else begin
            grant_cnt0_r <= grant_cnt0_r;
            grant_cnt1_r <= grant_cnt1_r;
        end
    end

    assign GrantCnt0 = grant_cnt0_r;
    assign GrantCnt1 = grant_cnt1_r;
`endif

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: one instance with EXEC_CYCLES=1 and one
// with EXEC_CYCLES=4, each sharing an And32 model as its ALU.
module tb_alu32_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;

    // EXEC_CYCLES = 1 instance
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [5:0]  req_op = 6'd0;
    logic [63:0] req_a = 64'd0;
    logic [63:0] req_b = 64'd0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = 2'b00;
    logic [31:0] rsp_data;
    logic [2:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        busy;

    // EXEC_CYCLES = 4 instance
    logic [1:0]  req_valid4 = 2'b00;
    logic [1:0]  req_ready4;
    logic [5:0]  req_op4 = 6'd0;
    logic [63:0] req_a4 = 64'd0;
    logic [63:0] req_b4 = 64'd0;
    logic [1:0]  rsp_valid4;
    logic [1:0]  rsp_ready4 = 2'b00;
    logic [31:0] rsp_data4;
    logic [2:0]  alu_op4;
    logic [31:0] alu_in1_4;
    logic [31:0] alu_in2_4;
    logic [31:0] alu_out4;
    logic        busy4;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
    logic [15:0] grant_cnt0_4;
    logic [15:0] grant_cnt1_4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    assign alu_out  = alu_in1 & alu_in2;
    assign alu_out4 = alu_in1_4 & alu_in2_4;

    alu32_arbiter #(.WIDTH(32), .OPW(3), .EXEC_CYCLES(1)) u_dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(req_valid), .ReqReady(req_ready), .ReqOp(req_op),
        .ReqA(req_a), .ReqB(req_b),
        .RspValid(rsp_valid), .RspReady(rsp_ready), .RspData(rsp_data),
        .AluOp(alu_op), .AluIn1(alu_in1), .AluIn2(alu_in2), .AluOut(alu_out),
        .Busy(busy)
`ifdef ALU_ARB_STATS_EN
        , .GrantCnt0(grant_cnt0), .GrantCnt1(grant_cnt1)
`endif
    );

    alu32_arbiter #(.WIDTH(32), .OPW(3), .EXEC_CYCLES(4)) u_dut4 (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(req_valid4), .ReqReady(req_ready4), .ReqOp(req_op4),
        .ReqA(req_a4), .ReqB(req_b4),
        .RspValid(rsp_valid4), .RspReady(rsp_ready4), .RspData(rsp_data4),
        .AluOp(alu_op4), .AluIn1(alu_in1_4), .AluIn2(alu_in2_4), .AluOut(alu_out4),
        .Busy(busy4)
`ifdef ALU_ARB_STATS_EN
        , .GrantCnt0(grant_cnt0_4), .GrantCnt1(grant_cnt1_4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the EXEC_CYCLES=1 instance. Called at a falling
    // edge in IDLE with requests already driven and RspReady for the winner set.
    task automatic serve(input logic [1:0] gm, input logic [31:0] ea,
                         input logic [31:0] ed, input logic [2:0] eop);
        #1;
        chk("req_ready_idle", {62'd0, req_ready}, {62'd0, gm});
        @(negedge Clk);
        chk("req_ready_exec", {62'd0, req_ready}, 64'd0);
        chk("busy_exec", {63'd0, busy}, 64'd1);
        chk("alu_in1_exec", {32'd0, alu_in1}, {32'd0, ea});
        chk("alu_op_exec", {61'd0, alu_op}, {61'd0, eop});
        chk("rsp_valid_exec", {62'd0, rsp_valid}, 64'd0);
        @(negedge Clk);
        chk("rsp_valid_resp", {62'd0, rsp_valid}, {62'd0, gm});
        chk("rsp_data_resp", {32'd0, rsp_data}, {32'd0, ed});
        chk("alu_in1_resp", {32'd0, alu_in1}, 64'd0);
        @(negedge Clk);
        chk("rsp_valid_idle", {62'd0, rsp_valid}, 64'd0);
        chk("rsp_data_idle", {32'd0, rsp_data}, 64'd0);
        chk("busy_idle", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0] gm;

        // Reset state
        @(negedge Clk);
        chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_alu_in1", {32'd0, alu_in1}, 64'd0);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        Rst = 1'b0;
        @(negedge Clk);
        chk("idle_req_ready", {62'd0, req_ready}, 64'd0);
        chk("idle_busy", {63'd0, busy}, 64'd0);

        // 1. Single request
        req_a     = {32'd0, 32'hF0F0_1234};
        req_b     = {32'd0, 32'h0FF0_FFFF};
        req_op    = 6'd0;
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        serve(2'b01, 32'hF0F0_1234, 32'h00F0_1234, 3'd0);
        req_valid = 2'b00;

        // 4. EXEC_CYCLES=4: operands held 4 cycles, response after edge N+4
        req_a4     = {32'd0, 32'h1234_5678};
        req_b4     = {32'd0, 32'hFFFF_0000};
        req_op4    = {3'd0, 3'd7};
        rsp_ready4 = 2'b01;
        req_valid4 = 2'b01;
        #1;
        chk("e4_req_ready", {62'd0, req_ready4}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            req_valid4 = 2'b00;
            chk("e4_alu_in1", {32'd0, alu_in1_4}, 64'h1234_5678);
            chk("e4_alu_in2", {32'd0, alu_in2_4}, 64'hFFFF_0000);
            chk("e4_alu_op", {61'd0, alu_op4}, 64'd7);
            chk("e4_rsp_valid_exec", {62'd0, rsp_valid4}, 64'd0);
        end
        @(negedge Clk);
        chk("e4_rsp_valid", {62'd0, rsp_valid4}, 64'd1);
        chk("e4_rsp_data", {32'd0, rsp_data4}, 64'h1234_0000);
        chk("e4_alu_in1_resp", {32'd0, alu_in1_4}, 64'd0);
        @(negedge Clk);
        chk("e4_busy_idle", {63'd0, busy4}, 64'd0);

        // 2. Simultaneous requests after reset, alternating grants
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        req_a     = {32'hAAAA_AAAA, 32'hFFFF_FFFF};
        req_b     = {32'h5555_5555, 32'hFFFF_FFFF};
        req_op    = {3'd2, 3'd5};
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        serve(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
        serve(2'b10, 32'hAAAA_AAAA, 32'h0000_0000, 3'd2);
        gm = 2'b01;
        for (int i = 0; i < 4; i++) begin
            if (gm == 2'b01) serve(gm, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
            else             serve(gm, 32'hAAAA_AAAA, 32'h0000_0000, 3'd2);
            gm = ~gm;
        end

        // 3. Response backpressure on requester 0 while requester 1 waits
        rsp_ready = 2'b10;
        #1;
        chk("bp_req_ready0", {62'd0, req_ready}, 64'd1);
        @(negedge Clk);
        req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("bp_rsp_valid", {62'd0, rsp_valid}, 64'd1);
            chk("bp_rsp_data", {32'd0, rsp_data}, 64'hFFFF_FFFF);
            chk("bp_req_ready1", {62'd0, req_ready}, 64'd0);
            chk("bp_busy", {63'd0, busy}, 64'd1);
        end
        rsp_ready = 2'b01;
        @(negedge Clk);
        chk("bp_after_req_ready", {62'd0, req_ready}, 64'd2);
        chk("bp_after_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        rsp_ready = 2'b11;
        @(negedge Clk);
        req_valid = 2'b00;
        chk("bp_r1_alu_in1", {32'd0, alu_in1}, 64'hAAAA_AAAA);
        @(negedge Clk);
        chk("bp_r1_rsp_valid", {62'd0, rsp_valid}, 64'd2);
        chk("bp_r1_rsp_data", {32'd0, rsp_data}, 64'd0);
        @(negedge Clk);
        chk("bp_r1_busy", {63'd0, busy}, 64'd0);

        // 5. Reset asserted mid-EXEC
        req_valid = 2'b01;
        serve(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
        req_valid = 2'b10;
        #1;
        chk("mr_req_ready", {62'd0, req_ready}, 64'd2);
        @(negedge Clk);
        chk("mr_alu_in1_exec", {32'd0, alu_in1}, 64'hAAAA_AAAA);
        Rst = 1'b1;
        #1;
        chk("mr_alu_in1", {32'd0, alu_in1}, 64'd0);
        chk("mr_alu_in2", {32'd0, alu_in2}, 64'd0);
        chk("mr_alu_op", {61'd0, alu_op}, 64'd0);
        chk("mr_busy", {63'd0, busy}, 64'd0);
        chk("mr_req_ready_rst", {62'd0, req_ready}, 64'd0);
        req_valid = 2'b00;
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("mr_no_rsp", {62'd0, rsp_valid}, 64'd0);
            chk("mr_idle_busy", {63'd0, busy}, 64'd0);
        end
        req_valid = 2'b11;
        serve(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
        serve(2'b10, 32'hAAAA_AAAA, 32'h0000_0000, 3'd2);
        serve(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
        serve(2'b10, 32'hAAAA_AAAA, 32'h0000_0000, 3'd2);
        req_valid = 2'b01;
        serve(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5);
        req_valid = 2'b00;

`ifdef ALU_ARB_STATS_EN
        // 6. Completion counters
        chk("stats_cnt0", {48'd0, grant_cnt0}, 64'd3);
        chk("stats_cnt1", {48'd0, grant_cnt1}, 64'd2);
        Rst = 1'b1;
        #1;
        chk("stats_cnt0_rst", {48'd0, grant_cnt0}, 64'd0);
        chk("stats_cnt1_rst", {48'd0, grant_cnt1}, 64'd0);
        @(negedge Clk);
        Rst = 1'b0;
`endif

        @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
